instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter: LATENCY, default 4, memory access delay in BUSY cycles; legal range 1..15.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RESET  input  1  asynchronous, active-low reset.
REQ-004 Port: READ  input  1  fetch request from CPU, level-held until the word is returned.
REQ-005 Port: ADDRESS  input  32  byte address (PC); only ADDRESS[9:0] used.
REQ-006 Port: LOAD_EN  input  1  preload write strobe, one byte per cycle.
REQ-007 Port: LOAD_ADDR  input  10  preload byte address.
REQ-008 Port: LOAD_DATA  input  8  preload byte.
REQ-009 Port: READDATA  output  32  fetched instruction word, registered.
REQ-010 Port: BUSYWAIT  output  1  stall request to CPU.
REQ-011 Port: MISALIGN  output  1  ADDRESS[1:0] of returned word was nonzero.

Function
REQ-012 Storage SHALL be 1024 x 8-bit bytes; a word is {mem[a+3], mem[a+2], mem[a+1], mem[a]} with a = {ADDRESS[9:2], 2'b00} (little-endian).
REQ-013 Address bits above [9] SHALL be ignored (wrap modulo 1024); ADDRESS[1:0] SHALL be forced to 0 for the access.
REQ-014 FSM states: IDLE, BUSY, RESP.
REQ-015 IDLE: on a rising edge with READ=1, latch word address and misalign flag, load counter with LATENCY-1, go to BUSY.
REQ-016 BUSY: each edge with READ=1 decrements counter; at an edge with counter=0, load READDATA from storage and MISALIGN from latch, go to RESP.
REQ-017 BUSY: any edge with READ=0 SHALL abort to IDLE; READDATA and MISALIGN unchanged.
REQ-018 RESP: lasts exactly one cycle, then IDLE unconditionally; READ still high in the following IDLE cycle starts a new access.
REQ-019 BUSYWAIT SHALL be combinational: 1 when (state=IDLE and READ=1) or state=BUSY; 0 otherwise.
REQ-020 Latency: READ rising in cycle 0 -> BUSYWAIT high cycles 0..LATENCY, READDATA valid and BUSYWAIT low in cycle LATENCY+1.
REQ-021 ADDRESS changes after the IDLE->BUSY edge SHALL NOT affect the access in flight.
REQ-022 Storage SHALL be sampled at the BUSY->RESP edge; a LOAD_EN write on that same edge to a byte of the word SHALL NOT be visible (old value returned).
REQ-023 LOAD_EN=1 writes LOAD_DATA to mem[LOAD_ADDR] on the rising edge in any state; it SHALL NOT alter FSM state or BUSYWAIT.
REQ-024 READDATA and MISALIGN SHALL hold their value between responses.

Reset
REQ-025 RESET=0 SHALL immediately force state IDLE, counter 0, READDATA=32'h0, MISALIGN=0, independent of CLK.
REQ-026 Reset SHALL NOT clear storage contents; LOAD_EN writes SHALL be blocked while RESET=0.
REQ-027 Reset asserted during BUSY or RESP SHALL discard the access; no response issued after release.
REQ-028 BUSYWAIT during reset SHALL be 0 regardless of READ.

Verification
REQ-029 Preload bytes 0..3 = 05,00,04,00; READ=1, ADDRESS=0, LATENCY=4 -> BUSYWAIT high 5 cycles, then READDATA=32'h00040005, MISALIGN=0, BUSYWAIT=0 one cycle.
REQ-030 ADDRESS=32'h00000406 with bytes 4..7 = 09,00,02,00 -> READDATA=32'h00020009, MISALIGN=1.
REQ-031 READ dropped in 2nd BUSY cycle -> IDLE next edge, BUSYWAIT=0, READDATA keeps prior value.
REQ-032 RESET=0 pulsed mid-BUSY (between edges) -> READDATA=0, BUSYWAIT=0 at once; after release, READ=1 to word 0 returns 32'h00040005 (storage retained).
REQ-033 Back-to-back: READ held, ADDRESS 0 then 4 after first RESP -> two responses spaced LATENCY+2 cycles apart, correct data each.
REQ-034 LOAD_EN to byte 0 (value 8'hAA) on the BUSY->RESP edge -> READDATA byte 0 = 05; next read returns 32'h000400AA.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: 1 KiB byte-preloadable store that returns
// little-endian 32-bit words after a fixed number of BUSY cycles.
module instr_mem_responder #(
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic [31:0] ADDRESS,
    input  logic        LOAD_EN,
    input  logic [9:0]  LOAD_ADDR,
    input  logic [7:0]  LOAD_DATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  count;
    logic [7:0]  word_addr;
    logic        misalign_lat;
    logic [7:0]  mem [0:1023];
    logic [31:0] word_data;
    logic        unused_addr;

    // Upper address bits wrap away; only the 1 KiB window is decoded.
    assign unused_addr = ^ADDRESS[31:10];

    assign word_data = {mem[{word_addr, 2'd3}], mem[{word_addr, 2'd2}],
                        mem[{word_addr, 2'd1}], mem[{word_addr, 2'd0}]};

    assign BUSYWAIT = RESET && (((state == IDLE) && READ) || (state == BUSY));

    // Storage survives reset; preload writes are simply ignored while it is held.
    always_ff @(posedge CLK) begin
        if (RESET && LOAD_EN) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            count        <= 4'd0;
            word_addr    <= 8'd0;
            misalign_lat <= 1'b0;
            READDATA     <= 32'h0;
            MISALIGN     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (READ) begin
                        word_addr    <= ADDRESS[9:2];
                        misalign_lat <= |ADDRESS[1:0];
                        count        <= COUNT_INIT;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (!READ) begin
                        state <= IDLE;
                    end else if (count == 4'd0) begin
                        // Nonblocking read sees pre-edge storage, so a same-edge preload is not returned.
                        READDATA <= word_data;
                        MISALIGN <= misalign_lat;
                        state    <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed and randomized bench for instr_mem_responder against a byte-array
// reference model of the memory and the cycle-level fetch timing.
module tb_instr_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read;
    logic [31:0] address;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [7:0]  load_data;
    logic [31:0] readdata;
    logic        busywait;
    logic        misalign;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  ref_mem [0:1023];
    logic [31:0] held_data;
    time         t_first;
    time         t_second;

    instr_mem_responder #(.LATENCY(LAT)) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .READ      (read),
        .ADDRESS   (address),
        .LOAD_EN   (load_en),
        .LOAD_ADDR (load_addr),
        .LOAD_DATA (load_data),
        .READDATA  (readdata),
        .BUSYWAIT  (busywait),
        .MISALIGN  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word at the 4-byte-aligned location within the 1 KiB window, little-endian.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a % 1024) / 4 * 4;
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        ref_mem[a] = d;
        step();
        load_en = 1'b0;
    endtask

    // One complete fetch starting in an IDLE cycle; returns the RESP time.
    task automatic do_read(input logic [31:0] a, input bit hold, input bit scramble,
                           input bit do_load, input logic [9:0] la, input logic [7:0] ld,
                           output time t_resp);
        logic [31:0] exp_data;
        logic        exp_mis;
        exp_data = model_word(a);
        exp_mis  = (a % 4) != 0;
        read    = 1'b1;
        address = a;
        #1;
        check("bw_request", busywait, 1);
        for (int i = 1; i <= LAT; i++) begin
            step();
            if (scramble) address = $urandom;
            #1;
            check("bw_busy", busywait, 1);
        end
        if (do_load) begin
            load_en   = 1'b1;
            load_addr = la;
            load_data = ld;
        end
        step();
        load_en = 1'b0;
        if (do_load) ref_mem[la] = ld;
        #1;
        t_resp = $time;
        check("bw_resp", busywait, 0);
        check("data_resp", readdata, exp_data);
        check("mis_resp", misalign, exp_mis);
        if (!hold) read = 1'b0;
        step();
        #1;
        check("bw_after", busywait, hold);
        check("data_hold", readdata, exp_data);
        held_data = exp_data;
    endtask

    initial begin
        time t_dummy;
        rst_n     = 1'b0;
        read      = 1'b0;
        address   = 32'h0;
        load_en   = 1'b0;
        load_addr = 10'h0;
        load_data = 8'h0;
        held_data = 32'h0;

        #3;
        check("rst_data", readdata, 32'h0);
        check("rst_mis", misalign, 0);
        read = 1'b1;
        #1;
        check("rst_bw_read", busywait, 0);
        read = 1'b0;
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 1024; i++) load_byte(10'(i), 8'($urandom));
        load_byte(10'd0, 8'h05);
        load_byte(10'd1, 8'h00);
        load_byte(10'd2, 8'h04);
        load_byte(10'd3, 8'h00);
        load_byte(10'd4, 8'h09);
        load_byte(10'd5, 8'h00);
        load_byte(10'd6, 8'h02);
        load_byte(10'd7, 8'h00);

        // Basic fetch of word 0 and a wrapped, misaligned fetch of word 1.
        do_read(32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0, t_dummy);
        check("word0_const", readdata, 32'h00040005);
        do_read(32'h00000406, 1'b0, 1'b1, 1'b0, 10'h0, 8'h0, t_dummy);
        check("word1_const", readdata, 32'h00020009);
        check("word1_mis", misalign, 1);

        // Abort by dropping READ in the second BUSY cycle.
        read    = 1'b1;
        address = 32'h8;
        step();
        step();
        read = 1'b0;
        #1;
        check("abort_bw_busy", busywait, 1);
        step();
        #1;
        check("abort_bw_idle", busywait, 0);
        check("abort_data", readdata, 32'h00020009);
        check("abort_mis", misalign, 1);
        for (int i = 0; i < LAT + 2; i++) step();
        check("abort_no_resp", readdata, 32'h00020009);

        // Asynchronous reset pulse mid-BUSY, with a preload attempt while held.
        read    = 1'b1;
        address = 32'h0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", readdata, 32'h0);
        check("midrst_mis", misalign, 0);
        check("midrst_bw", busywait, 0);
        load_en   = 1'b1;
        load_addr = 10'd0;
        load_data = 8'h77;
        step();
        load_en = 1'b0;
        check("midrst_bw2", busywait, 0);
        read = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) step();
        check("postrst_data", readdata, 32'h0);
        check("postrst_bw", busywait, 0);
        do_read(32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0, t_dummy);
        check("retained_const", readdata, 32'h00040005);

        // Back-to-back fetches with READ held throughout.
        do_read(32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 8'h0, t_first);
        do_read(32'h4, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0, t_second);
        check("b2b_spacing", 32'((t_second - t_first) / 10), LAT + 2);
        check("b2b_const", readdata, 32'h00020009);

        // Preload to byte 0 on the sampling edge is not seen until the next fetch.
        do_read(32'h0, 1'b0, 1'b0, 1'b1, 10'd0, 8'hAA, t_dummy);
        check("sameedge_old", readdata, 32'h00040005);
        do_read(32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0, t_dummy);
        check("sameedge_new", readdata, 32'h000400AA);

        // Randomized fetches: any address, optional hold, address churn, same-edge loads.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            logic [9:0]  la;
            a  = $urandom;
            la = ($urandom_range(0, 1) == 1) ? {a[9:2], 2'($urandom_range(0, 3))} : 10'($urandom);
            do_read(a, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                    la, 8'($urandom), t_dummy);
        end
        read = 1'b0;
        step();
        step();
        check("final_bw", busywait, 0);
        check("final_hold", readdata, held_data);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
